// File: rtl/fifo_lifo_buf.sv
// fifo_lifo_buf: parametrised token buffer for the ONP datapath.
// MODE=0 gives a circular FIFO (input/output queues); MODE=1 gives a stack
// (operator stack). Provides occupancy count, almost-full/almost-empty flags,
// synchronous flush and sticky overflow/underflow error flags.
module fifo_lifo_buf #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned MODE       = 0,
    parameter int unsigned AF_LVL     = (1 << DEPTH_LOG2) - 2,
    parameter int unsigned AE_LVL     = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  FI_STB,
    input  logic [WIDTH-1:0]      FI_DAT,
    output logic                  FI_BSY,
    output logic                  FO_STB,
    input  logic                  FO_ACK,
    output logic [WIDTH-1:0]      FO_DAT,
    output logic [DEPTH_LOG2:0]   FF_CNT,
    output logic                  FF_AF,
    output logic                  FF_AE,
    output logic                  FF_OVF,
    output logic                  FF_UNF
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned AW    = DEPTH_LOG2;

    // Storage array is deliberately left without reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic             r_ovf;
    logic             r_unf;

    logic             w_full;
    logic             w_empty;
    logic             w_clear;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic [CW-1:0]    w_cnt_m1;
    logic [CW-1:0]    w_cnt_nxt;

    // Handshake qualification, addressing and next occupancy.
    always_comb begin
        w_full    = (r_cnt == CW'(DEPTH));
        w_empty   = (r_cnt == '0);
        w_clear   = RST | FLUSH;
        w_push_ok = FI_STB & ~w_full;
        w_pop_ok  = FO_ACK & ~w_empty;
        w_wr_en   = w_push_ok & ~w_clear;
        w_cnt_m1  = r_cnt - CW'(1);
        w_wr_addr = r_wp;
        w_rd_addr = r_rp;
        w_cnt_nxt = r_cnt;

        if (MODE == 1) begin
            // Stack: top lives at cnt-1; push+pop together replaces the top.
            w_rd_addr = AW'(w_cnt_m1);
            if (w_push_ok && w_pop_ok) begin
                w_wr_addr = AW'(w_cnt_m1);
            end else begin
                w_wr_addr = AW'(r_cnt);
            end
        end

        if (w_push_ok && !w_pop_ok) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_cnt_nxt = w_cnt_m1;
        end
    end

    // Occupancy, pointers and sticky error flags; reset and flush clear alike.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            r_cnt <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_push_ok) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop_ok) begin
                r_rp <= r_rp + AW'(1);
            end
            if (FI_STB && w_full) begin
                r_ovf <= 1'b1;
            end
            if (FO_ACK && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Data array write port.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= FI_DAT;
        end
    end

    // Status and data outputs decoded from registered state.
    always_comb begin
        FI_BSY = w_full;
        FO_STB = ~w_empty;
        FF_CNT = r_cnt;
        FF_AF  = (32'(r_cnt) >= AF_LVL);
        FF_AE  = (32'(r_cnt) <= AE_LVL);
        FF_OVF = r_ovf;
        FF_UNF = r_unf;
        FO_DAT = w_empty ? '0 : r_mem[w_rd_addr];
    end

endmodule

// File: tb/tb_fifo_lifo_buf.sv
// Testbench for fifo_lifo_buf: FIFO (16), LIFO (16) and small FIFO (8) with
// custom flag levels, each checked against a queue-based reference model.
module tb_fifo_lifo_buf;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3];
    logic       flush [3];
    logic       stb [3];
    logic       ack [3];
    logic [7:0] din [3];

    logic [7:0] dat0, dat1, dat2;
    logic [4:0] cnt0, cnt1;
    logic [3:0] cnt2;
    logic bsy0, bsy1, bsy2, ostb0, ostb1, ostb2;
    logic af0, af1, af2, ae0, ae1, ae2;
    logic ovf0, ovf1, ovf2, unf0, unf1, unf2;

    fifo_lifo_buf #(.WIDTH(8), .DEPTH_LOG2(4), .MODE(0), .AF_LVL(14), .AE_LVL(1)) u_fifo (
        .CLK(clk), .RST(rst[0]), .FLUSH(flush[0]), .FI_STB(stb[0]), .FI_DAT(din[0]),
        .FI_BSY(bsy0), .FO_STB(ostb0), .FO_ACK(ack[0]), .FO_DAT(dat0), .FF_CNT(cnt0),
        .FF_AF(af0), .FF_AE(ae0), .FF_OVF(ovf0), .FF_UNF(unf0));

    fifo_lifo_buf #(.WIDTH(8), .DEPTH_LOG2(4), .MODE(1), .AF_LVL(14), .AE_LVL(1)) u_lifo (
        .CLK(clk), .RST(rst[1]), .FLUSH(flush[1]), .FI_STB(stb[1]), .FI_DAT(din[1]),
        .FI_BSY(bsy1), .FO_STB(ostb1), .FO_ACK(ack[1]), .FO_DAT(dat1), .FF_CNT(cnt1),
        .FF_AF(af1), .FF_AE(ae1), .FF_OVF(ovf1), .FF_UNF(unf1));

    fifo_lifo_buf #(.WIDTH(8), .DEPTH_LOG2(3), .MODE(0), .AF_LVL(6), .AE_LVL(1)) u_small (
        .CLK(clk), .RST(rst[2]), .FLUSH(flush[2]), .FI_STB(stb[2]), .FI_DAT(din[2]),
        .FI_BSY(bsy2), .FO_STB(ostb2), .FO_ACK(ack[2]), .FO_DAT(dat2), .FF_CNT(cnt2),
        .FF_AF(af2), .FF_AE(ae2), .FF_OVF(ovf2), .FF_UNF(unf2));

    int dep_a [3] = '{16, 16, 8};
    int mode_a [3] = '{0, 1, 0};
    int af_a [3] = '{14, 14, 6};

    // Reference model: one queue per instance, index 0 is the oldest entry.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    bit movf [3];
    bit munf [3];

    int n_cmp = 0;
    int n_err = 0;

    int         o_cnt;
    logic [7:0] o_dat;
    logic       o_stb, o_bsy, o_af, o_ae, o_ovf, o_unf;

    task automatic get_q(input int id, output logic [7:0] t [$]);
        case (id)
            0: t = q0;
            1: t = q1;
            default: t = q2;
        endcase
    endtask

    task automatic model_step(input int id, input bit s, input bit a, input logic [7:0] d,
                              input bit fl, input bit r);
        logic [7:0] t [$];
        bit full, empty, pu, po;
        get_q(id, t);
        full  = (t.size() == dep_a[id]);
        empty = (t.size() == 0);
        if (r || fl) begin
            t.delete();
            movf[id] = 1'b0;
            munf[id] = 1'b0;
        end else begin
            if (s && full) movf[id] = 1'b1;
            if (a && empty) munf[id] = 1'b1;
            pu = s && !full;
            po = a && !empty;
            if (mode_a[id] == 0) begin
                if (po) void'(t.pop_front());
                if (pu) t.push_back(d);
            end else if (pu && po) begin
                t[t.size() - 1] = d;
            end else if (po) begin
                void'(t.pop_back());
            end else if (pu) begin
                t.push_back(d);
            end
        end
        case (id)
            0: q0 = t;
            1: q1 = t;
            default: q2 = t;
        endcase
    endtask

    function automatic int e_cnt(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [7:0] e_dat(input int id);
        logic [7:0] t [$];
        case (id)
            0: t = q0;
            1: t = q1;
            default: t = q2;
        endcase
        if (t.size() == 0) return 8'h00;
        if (mode_a[id] == 1) return t[t.size() - 1];
        return t[0];
    endfunction

    task automatic obs(input int id);
        case (id)
            0: begin o_cnt = int'(cnt0); o_dat = dat0; o_stb = ostb0; o_bsy = bsy0;
                     o_af = af0; o_ae = ae0; o_ovf = ovf0; o_unf = unf0; end
            1: begin o_cnt = int'(cnt1); o_dat = dat1; o_stb = ostb1; o_bsy = bsy1;
                     o_af = af1; o_ae = ae1; o_ovf = ovf1; o_unf = unf1; end
            default: begin o_cnt = int'(cnt2); o_dat = dat2; o_stb = ostb2; o_bsy = bsy2;
                     o_af = af2; o_ae = ae2; o_ovf = ovf2; o_unf = unf2; end
        endcase
    endtask

    // One clock of stimulus on one instance; outputs sampled 1 time unit after the edge.
    task automatic cyc(input int id, input bit s, input bit a, input logic [7:0] d,
                       input bit fl, input bit r);
        stb[id] = s; ack[id] = a; din[id] = d; flush[id] = fl; rst[id] = r;
        @(posedge clk);
        model_step(id, s, a, d, fl, r);
        #1;
        stb[id] = 1'b0; ack[id] = 1'b0; flush[id] = 1'b0; rst[id] = 1'b0;
        obs(id);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs(i);
            n_cmp++; if (o_cnt !== 0) begin n_err++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, o_cnt); end
            n_cmp++; if (o_stb !== 1'b0 || o_bsy !== 1'b0) begin n_err++; $display("FAIL reset_stb_bsy[%0d]: got %b%b want 00", i, o_stb, o_bsy); end
            n_cmp++; if (o_dat !== 8'h00) begin n_err++; $display("FAIL reset_dat[%0d]: got %h want 00", i, o_dat); end
            n_cmp++; if (o_af !== 1'b0 || o_ae !== 1'b1) begin n_err++; $display("FAIL reset_af_ae[%0d]: got %b%b want 01", i, o_af, o_ae); end
            n_cmp++; if (o_ovf !== 1'b0 || o_unf !== 1'b0) begin n_err++; $display("FAIL reset_err[%0d]: got %b%b want 00", i, o_ovf, o_unf); end
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            n_cmp++; if (o_cnt !== i) begin n_err++; $display("FAIL fill_cnt: got %0d want %0d", o_cnt, i); end
            n_cmp++; if (o_dat !== 8'h01 || o_stb !== 1'b1) begin n_err++; $display("FAIL fill_head: got %h/%b want 01/1", o_dat, o_stb); end
        end
        n_cmp++; if (o_bsy !== 1'b1 || o_cnt !== 16) begin n_err++; $display("FAIL full_state: got bsy=%b cnt=%0d want 1/16", o_bsy, o_cnt); end
        for (int i = 0; i < 16; i++) begin
            obs(0);
            n_cmp++; if (o_dat !== 8'(i + 1)) begin n_err++; $display("FAIL drain_dat: got %h want %h", o_dat, 8'(i + 1)); end
            cyc(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        n_cmp++; if (o_stb !== 1'b0 || o_dat !== 8'h00 || o_ae !== 1'b1 || o_cnt !== 0)
            begin n_err++; $display("FAIL drained: got stb=%b dat=%h ae=%b cnt=%0d want 0/00/1/0", o_stb, o_dat, o_ae, o_cnt); end
    endtask

    task automatic test_wrap();
        int pushes [4] = '{10, 0, 12, 0};
        int pops [4] = '{0, 10, 0, 12};
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < pushes[ph]; k++) cyc(0, 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
            for (int k = 0; k < pops[ph]; k++) begin
                n_cmp++; if (o_dat !== e_dat(0)) begin n_err++; $display("FAIL wrap_dat: got %h want %h", o_dat, e_dat(0)); end
                cyc(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            end
        end
        n_cmp++; if (o_cnt !== 0) begin n_err++; $display("FAIL wrap_cnt: got %0d want 0", o_cnt); end
    endtask

    task automatic test_overflow();
        logic [7:0] second;
        for (int k = 0; k < 16; k++) cyc(0, 1'b1, 1'b0, 8'(8'h20 + k), 1'b0, 1'b0);
        second = 8'h21;
        cyc(0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        n_cmp++; if (o_cnt !== 15 || o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf: got cnt=%0d ovf=%b want 15/1", o_cnt, o_ovf); end
        n_cmp++; if (o_dat !== second) begin n_err++; $display("FAIL ovf_head: got %h want %h", o_dat, second); end
        for (int k = 0; k < 15; k++) cyc(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (o_unf !== 1'b1 || o_cnt !== 0 || o_ovf !== 1'b1) begin n_err++; $display("FAIL unf: got unf=%b cnt=%0d ovf=%b want 1/0/1", o_unf, o_cnt, o_ovf); end
        cyc(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (o_ovf !== 1'b0 || o_unf !== 1'b0) begin n_err++; $display("FAIL flush_flags: got %b%b want 00", o_ovf, o_unf); end
        // Push and pop on an empty buffer: no fall-through, the push lands.
        cyc(0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        n_cmp++; if (o_cnt !== 1 || o_unf !== 1'b1 || o_dat !== 8'h77) begin n_err++; $display("FAIL empty_pushpop: got cnt=%0d unf=%b dat=%h want 1/1/77", o_cnt, o_unf, o_dat); end
        cyc(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_lifo();
        cyc(1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
        cyc(1, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
        cyc(1, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b0);
        n_cmp++; if (o_dat !== 8'hA3) begin n_err++; $display("FAIL lifo_top: got %h want a3", o_dat); end
        cyc(1, 1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
        n_cmp++; if (o_dat !== 8'hB0 || o_cnt !== 3) begin n_err++; $display("FAIL lifo_replace: got %h/%0d want b0/3", o_dat, o_cnt); end
        n_cmp++; if (o_dat !== 8'hB0) begin n_err++; $display("FAIL lifo_pop0: got %h want b0", o_dat); end
        cyc(1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (o_dat !== 8'hA2) begin n_err++; $display("FAIL lifo_pop1: got %h want a2", o_dat); end
        cyc(1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (o_dat !== 8'hA1) begin n_err++; $display("FAIL lifo_pop2: got %h want a1", o_dat); end
        cyc(1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (o_stb !== 1'b0 || o_cnt !== 0) begin n_err++; $display("FAIL lifo_empty: got stb=%b cnt=%0d want 0/0", o_stb, o_cnt); end
    endtask

    task automatic test_flags();
        obs(2);
        for (int step = 0; step < 17; step++) begin
            n_cmp++; if (o_af !== (e_cnt(2) >= 6) || o_ae !== (e_cnt(2) <= 1))
                begin n_err++; $display("FAIL flags cnt=%0d: got af=%b ae=%b", e_cnt(2), o_af, o_ae); end
            n_cmp++; if (o_cnt !== e_cnt(2)) begin n_err++; $display("FAIL flags_cnt: got %0d want %0d", o_cnt, e_cnt(2)); end
            if (step < 8) cyc(2, 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
            else if (step < 16) cyc(2, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic test_rst_flush_mid();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 5; k++) cyc(0, 1'b1, 1'b0, 8'(8'h60 + k), 1'b0, 1'b0);
            cyc(0, 1'b1, 1'b0, 8'h99, pass == 1, pass == 0);
            n_cmp++; if (o_cnt !== 0 || o_stb !== 1'b0 || o_dat !== 8'h00)
                begin n_err++; $display("FAIL mid_clear%0d: got cnt=%0d stb=%b dat=%h want 0/0/00", pass, o_cnt, o_stb, o_dat); end
            cyc(0, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
            n_cmp++; if (o_dat !== 8'h42 || o_cnt !== 1) begin n_err++; $display("FAIL mid_after%0d: got %h/%0d want 42/1", pass, o_dat, o_cnt); end
            cyc(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int id = 0; id < 2; id++) begin
            for (int k = 0; k < 3; k++) cyc(id, 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
            for (int k = 0; k < 20; k++) begin
                cyc(id, 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
                n_cmp++; if (o_cnt !== 3 || o_dat !== e_dat(id))
                    begin n_err++; $display("FAIL b2b[%0d]: got cnt=%0d dat=%h want 3/%h", id, o_cnt, o_dat, e_dat(id)); end
            end
            cyc(id, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        int id, ec;
        bit s, a, fl, r;
        for (int n = 0; n < 1500; n++) begin
            id = int'($urandom_range(0, 2));
            // Bias toward filling in the first half of each window, draining in the second.
            if (((n / 100) % 2) == 0) begin
                s = ($urandom_range(0, 3) != 0); a = ($urandom_range(0, 3) == 0);
            end else begin
                s = ($urandom_range(0, 3) == 0); a = ($urandom_range(0, 3) != 0);
            end
            fl = ($urandom_range(0, 99) == 0);
            r  = ($urandom_range(0, 199) == 0);
            cyc(id, s, a, 8'($urandom), fl, r);
            ec = e_cnt(id);
            n_cmp++; if (o_cnt !== ec) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", id, o_cnt, ec); end
            n_cmp++; if (o_dat !== e_dat(id)) begin n_err++; $display("FAIL rnd_dat[%0d]: got %h want %h", id, o_dat, e_dat(id)); end
            n_cmp++; if (o_stb !== (ec != 0) || o_bsy !== (ec == dep_a[id]))
                begin n_err++; $display("FAIL rnd_stb_bsy[%0d]: got %b%b cnt=%0d", id, o_stb, o_bsy, ec); end
            n_cmp++; if (o_af !== (ec >= af_a[id]) || o_ae !== (ec <= 1))
                begin n_err++; $display("FAIL rnd_af_ae[%0d]: got %b%b cnt=%0d", id, o_af, o_ae, ec); end
            n_cmp++; if (o_ovf !== movf[id] || o_unf !== munf[id])
                begin n_err++; $display("FAIL rnd_err[%0d]: got %b%b want %b%b", id, o_ovf, o_unf, movf[id], munf[id]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; flush[i] = 1'b0; stb[i] = 1'b0; ack[i] = 1'b0; din[i] = 8'h00;
        end
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_wrap();
        test_overflow();
        test_lifo();
        test_flags();
        test_rst_flush_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
